imem_loader_ctrl: RTL and testbench
===================================

# imem_loader_ctrl

Controller that sequences program loading into the instruction memory and shares its address port between the CPU fetch path and a byte-serial loader (UART/debug bridge). During a load session it collects a stream of bytes, packs them little-endian into instruction words and issues one write per word. It stalls the CPU until the session ends, then returns the memory address port to the fetch PC.

## Interface
- `ADDR_WIDTH`, default 32: memory byte-address width.
- `DATA_WIDTH`, default 32: instruction word width; fixed at 4 bytes.
- `LEN_WIDTH`, default 16: width of the word-count field.
- `BASE_ADDR`, default 0: byte address of the first word written.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_start`  in  1: starts a session; sampled only in IDLE.
- `load_len`  in  LEN_WIDTH: number of words in the session; sampled with `load_start`.
- `byte_valid`  in  1: loader byte is valid.
- `byte_data`  in  8: loader byte.
- `byte_ready`  out  1: block accepts a byte.
- `fetch_addr`  in  ADDR_WIDTH: CPU PC.
- `mem_addr`  out  ADDR_WIDTH: address driven to the instruction memory.
- `mem_wr_en`  out  1: write strobe.
- `mem_wr_data`  out  DATA_WIDTH: write data.
- `cpu_stall`  out  1: holds the fetch stage.
- `busy`  out  1: a session is in progress.
- `load_done`  out  1: single-cycle completion pulse.
- `load_sum`  out  DATA_WIDTH: word checksum (see Configuration).

## Operation
**States**

- **IDLE**
  - `mem_addr = fetch_addr`.
  - `load_start=1` with `load_len==0` goes to DONE.
  - `load_start=1` with nonzero length goes to RECV; latches `load_len`, clears the word and byte counters, and clears `load_sum`.
- **RECV**
  - `byte_ready=1`.
  - A byte is accepted when `byte_valid & byte_ready`. Byte k (0..3) goes to bits [8k+7:8k].
  - Acceptance of byte 3 goes to WRITE.
- **WRITE**
  - Lasts one cycle. `mem_wr_en=1`, `mem_addr = BASE_ADDR + 4*word_cnt`, `mem_wr_data` = the packed word, `byte_ready=0`.
  - If `word_cnt == len-1`, go to DONE. Otherwise increment `word_cnt` and go to RECV.
- **DONE**
  - Lasts one cycle. `load_done=1`, then go to IDLE.

**Outputs by state**
- `cpu_stall = busy = (state != IDLE)`.
- `mem_addr = fetch_addr` in IDLE and DONE.
- `mem_wr_en` is high only in WRITE.

**Boundary conditions**
- `load_start` outside IDLE is ignored.
- Arithmetic: the word counter is LEN_WIDTH bits. The address computation wraps modulo 2^ADDR_WIDTH.
- Reset mid-session:
  - The block returns to IDLE and the partial word is discarded.
  - Words already written stay in memory.
  - No `load_done` pulse is issued.

## Timing
- Reset values:
  - `byte_ready=0`, `mem_wr_en=0`, `mem_wr_data=0`, `cpu_stall=0`, `busy=0`, `load_done=0`, `load_sum=0`.
  - `mem_addr` follows `fetch_addr` combinationally.
- `load_start` accepted at cycle t: RECV begins at t+1.
- Write latency: the 4th byte accepted at cycle c produces the write at c+1.
- Throughput with `byte_valid` held high: 5 cycles per word.
- Session duration:
  - N words: `load_done` at t+1+5N.
  - N=0: `load_done` at t+1.
- `cpu_stall` falls in the cycle after `load_done`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - `load_sum` accumulates the 32-bit wrap-around sum of every word written in the session.
  - It is cleared at session start and is valid from the cycle `load_done` is high until the next session starts.
- Not defined: `load_sum` is tied to 0 and no accumulator logic is built.

## Structure
- Package `imem_loader_pkg`:
  - state enum `{IDLE, RECV, WRITE, DONE}`.
  - `BYTES_PER_WORD = 4`.
  - `WORD_STRIDE = 4`.
- Sub-module `imem_word_packer`:
  - byte counter plus a 32-bit little-endian assembly register.
  - Inputs: `clk`, `rst`, `clear`, `byte_en`, `byte_data`.
  - Outputs: `word`, `word_full`.

## Test plan
- Reset held 2 cycles with `fetch_addr=0x40` → all outputs at their reset values; `mem_addr=0x40`.
- `load_len=1`, bytes 0x13,0x00,0x00,0x00 streamed back-to-back → one write of 0x00000013 at `BASE_ADDR`; `load_done` 6 cycles after `load_start`; `cpu_stall` high throughout the session.
- `load_len=3`, `byte_valid` toggling 1/0 → writes at addresses 0x0, 0x4, 0x8 in order; no byte lost or duplicated.
- `load_len=0` → `load_done` next cycle; `mem_wr_en` never asserted.
- `rst` asserted after 2 bytes of word 1 with `load_len=2` → only word 0 written; returns to IDLE; `cpu_stall=0`; no `load_done`.
- With the macro defined, words 0x00000001, 0x00000002, 0xFFFFFFFF → `load_sum=0x00000002`; a `load_start` pulse mid-session is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Word packing is fixed at four little-endian bytes.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_STRIDE    = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Collects loader bytes into a 32-bit little-endian instruction word.
// word_full flags the byte that completes the current word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_en) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_data;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = byte_en
                   & (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader_ctrl.sv
// Shares the imem address port between CPU fetch and a byte loader.
// Define IMEM_LOADER_CHECKSUM_EN to build the per-session word sum.
module imem_loader_ctrl
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  cpu_stall,
  output logic                  busy,
  output logic                  load_done,
  output logic [DATA_WIDTH-1:0] load_sum
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                 clear;
  logic                 byte_en;
  logic                 word_full;
  logic [31:0]          word;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign byte_en = byte_valid & byte_ready;
  assign wr_addr = BASE_ADDR
                 + ADDR_WIDTH'(wcnt_q) * ADDR_WIDTH'(WORD_STRIDE);

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .byte_en   (byte_en),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    clear      = 1'b0;
    byte_ready = 1'b0;
    mem_wr_en  = 1'b0;
    load_done  = 1'b0;
    mem_addr   = fetch_addr;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          clear  = 1'b1;
          len_d  = load_len;
          wcnt_d = '0;
          state_d = (load_len == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        mem_addr   = wr_addr;
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = wr_addr;
        if (wcnt_q == len_q - LEN_WIDTH'(1)) begin
          state_d = DONE;
        end else begin
          wcnt_d  = wcnt_q + LEN_WIDTH'(1);
          state_d = RECV;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign cpu_stall   = busy;
  assign mem_wr_data = DATA_WIDTH'(word);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear)          sum_d = '0;
    else if (mem_wr_en) sum_d = sum_q + mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign load_sum = sum_q;
`else
  assign load_sum = '0;
`endif

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench for imem_loader_ctrl: writes and done pulses
// are queued by the stimulus and checked by a negedge monitor.
module tb_imem_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [15:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        cpu_stall;
  logic        busy;
  logic        load_done;
  logic [31:0] load_sum;

  imem_loader_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_len    (load_len),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .fetch_addr  (fetch_addr),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .cpu_stall   (cpu_stall),
    .busy        (busy),
    .load_done   (load_done),
    .load_sum    (load_sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          at;
    logic [31:0] sum;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_sum(logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_stall) stall_cnt++;
      if (mem_wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'h1, 32'h0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wr_data, w.data);
        end
      end
      if (load_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          dn_t d;
          d = dq.pop_front();
          if (d.at >= 0) chk("done_cycle", cyc, d.at);
          chk("load_sum", load_sum, d.sum);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [15:0] len);
    load_start = 1'b1;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    logic ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("byte_timeout", 32'h1, 32'h0);
    byte_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_word(logic [31:0] w, int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", 32'h1, 32'h0);
    step();
  endtask

  int t;

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    fetch_addr = 32'h40;
    repeat (2) step();
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'h0);
    chk("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, load_done}, 32'h0);
    chk("rst_sum", load_sum, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h40);
    rst = 1'b0;
    step();

    // one word, back-to-back bytes
    stall_cnt = 0;
    t = cyc;
    wq.push_back('{32'h0, 32'h0000_0013});
    dq.push_back('{t + 6, exp_sum(32'h13)});
    start(16'd1);
    send_word(32'h0000_0013, 0);
    wait_idle();
    chk("stall_cycles", stall_cnt, 32'd6);
    chk("stall_after", {31'b0, cpu_stall}, 32'h0);
    fetch_addr = 32'h1234_5678;
    #1;
    chk("idle_mem_addr", mem_addr, 32'h1234_5678);

    // three words with byte_valid toggling
    wq.push_back('{32'h0, 32'h4433_2211});
    wq.push_back('{32'h4, 32'h8877_6655});
    wq.push_back('{32'h8, 32'hDDCC_BBAA});
    dq.push_back('{-1, exp_sum(32'hAA77_4410)});
    start(16'd3);
    send_word(32'h4433_2211, 1);
    send_word(32'h8877_6655, 1);
    send_word(32'hDDCC_BBAA, 1);
    wait_idle();

    // zero-length session
    t = cyc;
    dq.push_back('{t + 1, exp_sum(32'h0)});
    start(16'd0);
    wait_idle();

    // reset in the middle of word 1
    wq.push_back('{32'h0, 32'hDEAD_BEEF});
    start(16'd2);
    send_word(32'hDEAD_BEEF, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_ready", {31'b0, byte_ready}, 32'h0);
    repeat (8) step();

    // checksum wrap plus an ignored load_start
    t = cyc;
    wq.push_back('{32'h0, 32'h0000_0001});
    wq.push_back('{32'h4, 32'h0000_0002});
    wq.push_back('{32'h8, 32'hFFFF_FFFF});
    dq.push_back('{t + 16, exp_sum(32'h0000_0002)});
    start(16'd3);
    send_word(32'h0000_0001, 0);
    load_start = 1'b1;
    load_len   = 16'd0;
    send_word(32'h0000_0002, 0);
    load_start = 1'b0;
    send_word(32'hFFFF_FFFF, 0);
    wait_idle();

    repeat (3) step();
    chk("wq_empty", wq.size(), 32'd0);
    chk("dq_empty", dq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
